spi_master_arbiter: RTL

Master-side controller that shares one SPI link to a 32-bit SPI slave among NUM_REQ on-chip requesters. It arbitrates round-robin and runs one full-duplex frame per grant: SS low, DATA_LENGTH SCLK pulses in mode 0, MSB first. It then returns the word shifted in on MISO, tagged with the requester index. The block sits between the system-clock fabric and the SPI pins and generates SCLK, SS and MOSI from `clk`.

---
 rtl/spi_master_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - round-robin arbiter sharing one mode-0 SPI master link among NUM_REQ requesters
// One full-duplex frame per grant; the received word is returned tagged with the requester index.
module spi_master_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_LENGTH = 32,
  parameter int CLK_DIV     = 4,
  parameter int SS_GAP      = 2,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             gnt,
  output logic                           rsp_valid,
  output logic [ID_W-1:0]                rsp_id,
  output logic [DATA_LENGTH-1:0]         rsp_data,
  output logic                           busy,
  output logic                           SCLK,
  output logic                           SS,
  output logic                           MOSI,
  input  logic                           MISO
);

  localparam int CNT_MAX = (CLK_DIV > SS_GAP) ? CLK_DIV : SS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(SS_GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_LENGTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_GAP} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [ID_W-1:0]        win_q, win_d;
  logic [DATA_LENGTH-1:0] tx_q, tx_d;
  logic [DATA_LENGTH-1:0] rx_q, rx_d;
  logic [ID_W-1:0]        rsp_id_q, rsp_id_d;
  logic [DATA_LENGTH-1:0] rsp_data_q, rsp_data_d;
  logic                   arb_en_q, arb_en_d;

  logic [ID_W-1:0]        pick;
  logic                   any_req;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Scan downwards so the lowest offset from ptr_q wins.
  always_comb begin
    pick    = ptr_q;
    any_req = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[wrap_add(ptr_q, k)]) pick = wrap_add(ptr_q, k);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    arb_en_d   = arb_en_q;
    case (state_q)
      S_IDLE: begin
        arb_en_d = 1'b1;
        if (arb_en_q && any_req) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          bit_d   = '0;
          win_d   = pick;
          ptr_d   = wrap_add(pick, 1);
          tx_d    = req_data[int'(pick)*DATA_LENGTH +: DATA_LENGTH];
        end
      end
      S_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (cnt_q == DIV_LAST) begin
          rx_d    = {rx_q[DATA_LENGTH-2:0], MISO};
          tx_d    = {tx_q[DATA_LENGTH-2:0], 1'b0};
          state_d = S_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOW: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d    = S_GAP;
            rsp_data_d = rx_q;
            rsp_id_d   = win_q;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            state_d = S_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          // One turnaround IDLE cycle keeps the next grant SS_GAP+2 cycles after rsp_valid.
          state_d  = S_IDLE;
          cnt_d    = '0;
          arb_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      ptr_q      <= '0;
      win_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      arb_en_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      arb_en_q   <= arb_en_d;
    end
  end

  always_comb begin
    SS        = !((state_q == S_SETUP) || (state_q == S_HIGH) || (state_q == S_LOW));
    SCLK      = (state_q == S_HIGH);
    MOSI      = !SS && tx_q[DATA_LENGTH-1];
    busy      = (state_q != S_IDLE);
    gnt       = ((state_q == S_SETUP) && (cnt_q == '0)) ? (NUM_REQ'(1) << win_q) : '0;
    rsp_valid = (state_q == S_GAP) && (cnt_q == '0);
    rsp_id    = rsp_id_q;
    rsp_data  = rsp_data_q;
  end

endmodule
